dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one request at a time, inserts
// WAIT wait states, then returns a one-cycle Ready strobe with read data/error.
module dmem_responder #(
  parameter int WAIT = 2,
  parameter int AW   = 6
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Req,
  input  logic          MemWrite,
  input  logic [31:0]   Addr,
  input  logic [31:0]   WriteData,
  input  logic [3:0]    ByteEn,
  output logic          Ready,
  output logic [31:0]   ReadData,
  output logic          Error,
  input  logic [AW-1:0] ReadMem,
  output logic [31:0]   MemData
);

  // Handshake: Req is a level held with Addr/MemWrite/WriteData/ByteEn stable
  // until Ready; Ready pulses for exactly one cycle per accepted request, and
  // a request is only accepted in IDLE, so there is at least one idle cycle
  // between back-to-back responses.

  typedef enum logic [1:0] {stIdle, stWait, stResp} stateT;

  localparam bit         NoWait  = (WAIT == 0);
  localparam logic [3:0] CntInit = NoWait ? 4'd0 : 4'(WAIT - 1);

  logic [31:0] mem [2**AW];

  stateT       state, nextState;
  logic [3:0]  count, nextCount;
  logic        captureEn, enterResp;

  logic [AW+1:0] capAddr;
  logic          capWrite;
  logic [31:0]   capData;
  logic [3:0]    capBe;

  logic [AW+1:0] selAddr;
  logic          selWrite;
  logic [31:0]   selData;
  logic [3:0]    selBe;
  logic [AW-1:0] selIdx;
  logic          selMis;
  logic          commit;

  logic unusedAddr;
  assign unusedAddr = ^Addr[31:AW+2];

  always_comb begin
    nextState = state;
    nextCount = count;
    captureEn = 1'b0;
    enterResp = 1'b0;
    case (state)
      stIdle: begin
        if (Req) begin
          captureEn = 1'b1;
          if (NoWait || (Addr[1:0] != 2'b00)) begin
            nextState = stResp;
            enterResp = 1'b1;
          end else begin
            nextState = stWait;
            nextCount = CntInit;
          end
        end
      end
      stWait: begin
        if (count == 4'd0) begin
          nextState = stResp;
          enterResp = 1'b1;
        end else begin
          nextCount = count - 4'd1;
        end
      end
      stResp:  nextState = stIdle;
      default: nextState = stIdle;
    endcase
  end

  // When RESP is entered straight from IDLE the live inputs have not been
  // captured yet, so the transaction is taken from the ports in that case.
  always_comb begin
    selAddr  = (state == stIdle) ? Addr[AW+1:0] : capAddr;
    selWrite = (state == stIdle) ? MemWrite     : capWrite;
    selData  = (state == stIdle) ? WriteData    : capData;
    selBe    = (state == stIdle) ? ByteEn       : capBe;
    selIdx   = selAddr[AW+1:2];
    selMis   = (selAddr[1:0] != 2'b00);
    commit   = enterResp && !selMis && selWrite;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= stIdle;
      count    <= 4'd0;
      Ready    <= 1'b0;
      Error    <= 1'b0;
      ReadData <= 32'd0;
      capAddr  <= '0;
      capWrite <= 1'b0;
      capData  <= 32'd0;
      capBe    <= 4'd0;
    end else begin
      state <= nextState;
      count <= nextCount;
      Ready <= enterResp;
      Error <= enterResp && selMis;
      if (enterResp) ReadData <= selMis ? 32'd0 : mem[selIdx];
      if (captureEn) begin
        capAddr  <= Addr[AW+1:0];
        capWrite <= MemWrite;
        capData  <= WriteData;
        capBe    <= ByteEn;
      end
    end
  end

  // Array has no reset; Reset still blocks a commit on a coincident edge.
  always_ff @(posedge CLK) begin
    if (commit && !Reset) begin
      for (int i = 0; i < 4; i++) begin
        if (selBe[i]) mem[selIdx][8*i +: 8] <= selData[8*i +: 8];
      end
    end
  end

  assign MemData = mem[ReadMem];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, hand sequences for reset abort and
// back-to-back requests, and randomized traffic against a byte-level memory model.
module tb_dmem_responder;

  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          req0, req1;
  logic          memWrite;
  logic [31:0]   addr, writeData;
  logic [3:0]    byteEn;
  logic [AW-1:0] readMem;
  logic          ready0, ready1, err0, err1;
  logic [31:0]   rdata0, rdata1, mdata0, mdata1;

  dmem_responder #(.WAIT(2), .AW(AW)) dut0 (
    .CLK(clk), .Reset(rst), .Req(req0), .MemWrite(memWrite), .Addr(addr),
    .WriteData(writeData), .ByteEn(byteEn), .Ready(ready0), .ReadData(rdata0),
    .Error(err0), .ReadMem(readMem), .MemData(mdata0)
  );

  dmem_responder #(.WAIT(0), .AW(AW)) dut1 (
    .CLK(clk), .Reset(rst), .Req(req1), .MemWrite(memWrite), .Addr(addr),
    .WriteData(writeData), .ByteEn(byteEn), .Ready(ready1), .ReadData(rdata1),
    .Error(err1), .ReadMem(readMem), .MemData(mdata1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // behavioural model: per-DUT word contents plus a mask of bytes ever written
  logic [31:0] modelWord [2][2**AW];
  logic [3:0]  modelKnown [2][2**AW];

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    int          expLat;
    bit          chkData;
    logic [31:0] expData;
    bit          expErr;
  } vecT;

  vecT vec [12];

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? ready0 : ready1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called just after the accepting posedge; returns negedge index of Ready
  task automatic waitReady(input int d, output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy(d)) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: dut%0d gave no Ready within 20 cycles", d);
    end
  endtask

  // driver: one transaction, entered and left at a negedge
  task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output int lat, output logic [31:0] rd, output logic er);
    memWrite = wr; addr = a; writeData = wd; byteEn = be;
    if (d == 0) req0 = 1'b1; else req1 = 1'b1;
    @(posedge clk);
    waitReady(d, lat);
    rd = (d == 0) ? rdata0 : rdata1;
    er = (d == 0) ? err0 : err1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", {31'd0, rdy(d)}, 32'd0);
  endtask

  // transaction checked against the model, which is then updated
  task automatic runOne(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int lat, output logic [31:0] rd, output logic er);
    int          w;
    bit          mis;
    int          expLat;
    logic [31:0] m;
    w = int'(a[AW+1:2]);
    mis = (a[1:0] != 2'b00);
    expLat = mis ? 0 : ((d == 0) ? 2 : 0);
    txn(d, wr, a, wd, be, lat, rd, er);
    chk("latency", lat, expLat);
    chk("error", {31'd0, er}, {31'd0, mis});
    if (mis) begin
      chk("misaligned_data", rd, 32'd0);
    end else if (!wr) begin
      m = expand(modelKnown[d][w]);
      chk("read_data", rd & m, modelWord[d][w] & m);
    end
    if (wr && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          modelWord[d][w][8*i +: 8] = wd[8*i +: 8];
          modelKnown[d][w][i] = 1'b1;
        end
      end
    end
    readMem = AW'(w);
    #1;
    m = expand(modelKnown[d][w]);
    chk("mem_data", ((d == 0) ? mdata0 : mdata1) & m, modelWord[d][w] & m);
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          idleCycles;
    bit          wr;
    logic [31:0] a;

    vec[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'h0,        1'b0};
    vec[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2, 1'b1, 32'hDEADBEEF, 1'b0};
    vec[2]  = '{1'b1, 32'h08, 32'h00112233, 4'h5, 2, 1'b0, 32'h0,        1'b0};
    vec[3]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2, 1'b1, 32'hDE11BE33, 1'b0};
    vec[4]  = '{1'b0, 32'h0A, 32'h0,        4'h0, 0, 1'b1, 32'h0,        1'b1};
    vec[5]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2, 1'b1, 32'hDE11BE33, 1'b0};
    vec[6]  = '{1'b1, 32'h0C, 32'hAAAA5555, 4'hF, 2, 1'b0, 32'h0,        1'b0};
    vec[7]  = '{1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0, 2, 1'b0, 32'h0,        1'b0};
    vec[8]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 2, 1'b1, 32'hAAAA5555, 1'b0};
    vec[9]  = '{1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 2, 1'b0, 32'h0,        1'b0};
    vec[10] = '{1'b1, 32'h09, 32'h0BADBAD0, 4'hF, 0, 1'b1, 32'h0,        1'b1};
    vec[11] = '{1'b0, 32'h08, 32'h0,        4'h0, 2, 1'b1, 32'hDE11BE33, 1'b0};

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 2**AW; w++) begin
        modelWord[d][w] = 32'd0;
        modelKnown[d][w] = 4'd0;
      end

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; memWrite = 1'b0;
    addr = 32'd0; writeData = 32'd0; byteEn = 4'd0; readMem = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready0", {31'd0, ready0}, 32'd0);
    chk("reset_error0", {31'd0, err0}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_ready1", {31'd0, ready1}, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed table on the WAIT=2 instance
    for (int i = 0; i < 12; i++) begin
      runOne(0, vec[i].wr, vec[i].a, vec[i].wd, vec[i].be, lat, rd, er);
      chk("vec_latency", lat, vec[i].expLat);
      chk("vec_error", {31'd0, er}, {31'd0, vec[i].expErr});
      if (vec[i].chkData) chk("vec_data", rd, vec[i].expData);
    end

    // reset during wait states aborts the write to word 4
    memWrite = 1'b1; addr = 32'h10; writeData = 32'h12345678; byteEn = 4'hF; req0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready0}, 32'd0);
    chk("abort_error", {31'd0, err0}, 32'd0);
    chk("abort_rdata", rdata0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idleCycles = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready0) idleCycles++;
    end
    chk("abort_no_ready", idleCycles, 0);
    readMem = AW'(4);
    #1;
    chk("abort_memdata", mdata0, 32'hCAFEF00D);
    @(negedge clk);

    // Req held high across two reads
    memWrite = 1'b0; addr = 32'h0C; req0 = 1'b1;
    @(posedge clk);
    waitReady(0, lat);
    chk("b2b_lat0", lat, 2);
    chk("b2b_data0", rdata0, 32'hAAAA5555);
    addr = 32'h10;
    @(negedge clk);
    chk("b2b_gap", {31'd0, ready0}, 32'd0);
    @(posedge clk);
    waitReady(0, lat);
    chk("b2b_lat1", lat, 2);
    chk("b2b_data1", rdata0, 32'hCAFEF00D);
    req0 = 1'b0;
    @(negedge clk);

    // WAIT=0 instance: write then read word 1
    runOne(1, 1'b1, 32'h04, 32'h5A5AC3C3, 4'hF, lat, rd, er);
    chk("w0_write_lat", lat, 0);
    runOne(1, 1'b0, 32'h04, 32'h0, 4'h0, lat, rd, er);
    chk("w0_read_lat", lat, 0);
    chk("w0_read_data", rd, 32'h5A5AC3C3);

    // randomized traffic on both instances
    for (int i = 0; i < 60; i++) begin
      wr = ($urandom_range(0, 1) == 1);
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      runOne((i < 40) ? 0 : 1, wr, a, $urandom, 4'($urandom_range(0, 15)), lat, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
